// File: rtl/axis_noc_packetizer.sv
// AXI-Stream to NoC packetizer: buffers up to MAX_PACKAGES beats per segment, then
// emits a header flit (dest, exact length, frame-end) followed by the buffered payload.
module axis_noc_packetizer #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    parameter int MAX_PACKAGES  = 4,
    localparam int X_W   = $clog2(MAX_ROUTERS_X),
    localparam int Y_W   = $clog2(MAX_ROUTERS_Y),
    localparam int LEN_W = (MAX_PACKAGES > 1) ? $clog2(MAX_PACKAGES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_tdata_i,
    input  logic                  s_tvalid_i,
    input  logic                  s_tlast_i,
    output logic                  s_tready_o,
    input  logic [X_W-1:0]        dest_x_i,
    input  logic [Y_W-1:0]        dest_y_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    output logic                  m_tlast_o,
    input  logic                  m_tready_i,
    output logic                  busy_o
);
    localparam int CNT_W = $clog2(MAX_PACKAGES + 1);
    localparam int DEPTH = 1 << LEN_W;

    if (X_W + Y_W + LEN_W + 1 > DATA_WIDTH) begin : g_bad_width
        $error("header fields do not fit in DATA_WIDTH");
    end
    if (MAX_PACKAGES < 1) begin : g_bad_pkg
        $error("MAX_PACKAGES must be at least 1");
    end

    typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      rd_ptr;
    logic [X_W-1:0]        dx;
    logic [Y_W-1:0]        dy;
    logic                  frame_open;
    logic                  seg_end;
    logic                  accept;
    logic                  seg_close;
    logic [DATA_WIDTH-1:0] hdr;

    assign s_tready_o = (state == COLLECT) && !rst_i;
    assign accept     = s_tvalid_i && s_tready_o;
    assign seg_close  = s_tlast_i || (cnt == CNT_W'(MAX_PACKAGES - 1));
    assign busy_o     = frame_open;

    // Header is built from the beat closing the segment; the first beat of a frame
    // supplies the destination directly since dx/dy are only latched on that edge.
    always_comb begin
        hdr = '0;
        hdr[X_W-1:0]             = frame_open ? dx : dest_x_i;
        hdr[X_W +: Y_W]          = frame_open ? dy : dest_y_i;
        hdr[X_W+Y_W +: LEN_W]    = cnt[LEN_W-1:0];
        hdr[X_W+Y_W+LEN_W]       = s_tlast_i;
    end

    always_ff @(posedge clk_i) begin
        if (accept) mem[cnt[LEN_W-1:0]] <= s_tdata_i;
    end

    // rd_ptr runs one entry ahead of the flit on m_tdata_o so the next flit can be
    // registered on each handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= COLLECT;
            cnt        <= '0;
            rd_ptr     <= '0;
            frame_open <= 1'b0;
            seg_end    <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            m_tvalid_o <= 1'b0;
            m_tlast_o  <= 1'b0;
            m_tdata_o  <= '0;
        end else begin
            case (state)
                COLLECT: if (accept) begin
                    cnt <= cnt + CNT_W'(1);
                    if (!frame_open) begin
                        dx         <= dest_x_i;
                        dy         <= dest_y_i;
                        frame_open <= 1'b1;
                    end
                    if (seg_close) begin
                        state      <= HEADER;
                        seg_end    <= s_tlast_i;
                        m_tvalid_o <= 1'b1;
                        m_tlast_o  <= 1'b0;
                        m_tdata_o  <= hdr;
                    end
                end
                HEADER: if (m_tready_i) begin
                    state     <= PAYLOAD;
                    m_tdata_o <= mem[0];
                    m_tlast_o <= (cnt == CNT_W'(1));
                    rd_ptr    <= CNT_W'(1);
                end
                PAYLOAD: if (m_tready_i) begin
                    if (m_tlast_o) begin
                        state      <= COLLECT;
                        cnt        <= '0;
                        rd_ptr     <= '0;
                        m_tvalid_o <= 1'b0;
                        m_tlast_o  <= 1'b0;
                        m_tdata_o  <= '0;
                        if (seg_end) frame_open <= 1'b0;
                    end else begin
                        m_tdata_o <= mem[rd_ptr[LEN_W-1:0]];
                        m_tlast_o <= (rd_ptr == cnt - CNT_W'(1));
                        rd_ptr    <= rd_ptr + CNT_W'(1);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_noc_packetizer.sv
// Directed bench for axis_noc_packetizer: a frame-level model predicts every output
// flit, a monitor checks handshakes and AXIS stability, literals pin header encoding.
module tb_axis_noc_packetizer;
    localparam int MP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [1:0]  dest_x = '0;
    logic [1:0]  dest_y = '0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        busy;

    always #5 clk = ~clk;

    axis_noc_packetizer dut (
        .clk_i(clk), .rst_i(rst),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
        .dest_x_i(dest_x), .dest_y_i(dest_y),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
        .busy_o(busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] log_q[$];
    int          rmode = 0;
    bit          rstarted = 1'b0;
    int          rhold = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int x, input int y, input int len, input int e);
        return 32'(x + y * 4 + len * 16 + e * 64);
    endfunction

    // Frame -> packets: chunks of MP beats, each led by a header with exact length.
    task automatic expect_frame(input int n, input logic [31:0] base, input int x, input int y);
        for (int s = 0; s < n; s += MP) begin
            int len;
            len = (n - s < MP) ? n - s : MP;
            exp_q.push_back({1'b0, hdr(x, y, len - 1, (s + len == n) ? 1 : 0)});
            for (int i = 0; i < len; i++)
                exp_q.push_back({(i == len - 1), base + 32'(s + i)});
        end
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input int x, input int y,
                              input int chg_at, input int nx, input int ny);
        for (int i = 0; i < n; i++) begin
            int t;
            bit acc;
            t = 0;
            acc = 1'b0;
            s_tvalid = 1'b1;
            s_tdata  = base + 32'(i);
            s_tlast  = (i == n - 1);
            dest_x   = (chg_at >= 0 && i >= chg_at) ? 2'(nx) : 2'(x);
            dest_y   = (chg_at >= 0 && i >= chg_at) ? 2'(ny) : 2'(y);
            do begin
                @(negedge clk) acc = s_tready;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 200);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: beat %0d not accepted, s_tready %0b required 1", i, s_tready);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_ready", s_tready, 1);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
        if (idx < log_q.size()) chk(name, log_q[idx], exp);
        else begin
            checks++;
            errors++;
            $display("FAIL %s: only %0d flits logged, required index %0d", name, log_q.size(), idx);
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = hold low 5 cycles from header then toggle, 3 = manual.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: m_tready = 1'b1;
            1: if (!rstarted) begin
                   m_tready = 1'b0;
                   if (m_tvalid) begin
                       rstarted = 1'b1;
                       rhold = 4;
                   end
               end else if (rhold > 0) begin
                   rhold--;
                   m_tready = 1'b0;
               end else m_tready = ~m_tready;
            default: ;
        endcase
    end

    logic        pv = 1'b0;
    logic [32:0] pd = '0;
    logic        prst = 1'b1;

    always @(negedge clk) begin
        if (!rst && !prst) begin
            chk("no_overlap", {63'd0, m_tvalid & s_tready}, 0);
            if (pv) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_flit", {m_tlast, m_tdata}, pd);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit: got %0h with no flit expected", {m_tlast, m_tdata});
                end else begin
                    chk("flit", {m_tlast, m_tdata}, exp_q.pop_front());
                    log_q.push_back(m_tdata);
                end
            end
        end
        pv   = m_tvalid && !m_tready && !rst;
        pd   = {m_tlast, m_tdata};
        prst = rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tready", s_tready, 1);
        @(posedge clk);
        #1;

        // T1: 3-beat frame to (2,1)
        log_q.delete();
        expect_frame(3, 32'hA000_0000, 2, 1);
        send_frame(3, 32'hA000_0000, 2, 1, -1, 0, 0);
        chk("t1_busy", busy, 1);
        drain();
        chk_log("t1_hdr", 0, 32'h66);
        chk_log("t1_last", 3, 32'hA000_0002);

        // T2: 10-beat frame to (3,3) -> 4,4,2 payload flits
        log_q.delete();
        expect_frame(10, 32'hB000_0000, 3, 3);
        send_frame(10, 32'hB000_0000, 3, 3, -1, 0, 0);
        drain();
        chk_log("t2_hdr0", 0, 32'h3F);
        chk_log("t2_hdr1", 5, 32'h3F);
        chk_log("t2_hdr2", 10, 32'h5F);
        chk_log("t2_tail", 12, 32'hB000_0009);

        // T3: T1 under backpressure
        log_q.delete();
        rstarted = 1'b0;
        rmode = 1;
        expect_frame(3, 32'hA000_0000, 2, 1);
        send_frame(3, 32'hA000_0000, 2, 1, -1, 0, 0);
        drain();
        rmode = 0;
        chk_log("t3_hdr", 0, 32'h66);
        chk("t3_count", 64'(log_q.size()), 4);

        // T4: exactly MP beats to (1,0), then a single beat to (0,2)
        log_q.delete();
        expect_frame(4, 32'hC000_0000, 1, 0);
        expect_frame(1, 32'hC100_0000, 0, 2);
        send_frame(4, 32'hC000_0000, 1, 0, -1, 0, 0);
        send_frame(1, 32'hC100_0000, 0, 2, -1, 0, 0);
        drain();
        chk_log("t4_hdr1", 0, 32'h71);
        chk_log("t4_hdr2", 5, 32'h48);

        // T5: reset while the second payload flit is pending
        rmode = 3;
        m_tready = 1'b1;
        expect_frame(4, 32'hD000_0000, 3, 2);
        send_frame(4, 32'hD000_0000, 3, 2, -1, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        log_q.delete();
        @(negedge clk);
        chk("t5_tvalid", m_tvalid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_tready", s_tready, 1);
        @(posedge clk);
        #1;
        rmode = 0;
        expect_frame(2, 32'hD100_0000, 1, 1);
        send_frame(2, 32'hD100_0000, 1, 1, -1, 0, 0);
        drain();
        chk_log("t5_hdr", 0, 32'h55);

        // T6: dest changed between segments of a 6-beat frame
        log_q.delete();
        expect_frame(6, 32'hE000_0000, 2, 3);
        send_frame(6, 32'hE000_0000, 2, 3, 4, 0, 0);
        drain();
        chk_log("t6_hdr1", 0, 32'h3E);
        chk_log("t6_hdr2", 5, 32'h5E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
